// File: rtl/cvxif_sched_pkg.sv
// ---------------------------------------------------------------------------
// cvxif_sched_pkg
// Shared types and constants for the CV-X-IF issue scheduler.
//   OPCODE_W       : width of the decoded coprocessor opcode
//   REG_ADDR_W     : width of an integer register index (rd)
//   sched_state_e  : dispatch FSM states (IDLE, EXEC, RESP)
//   entry_status_t : commit/kill tracking bits carried by every queue entry
// ---------------------------------------------------------------------------
package cvxif_sched_pkg;

  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // killed is only ever set together with committed, so a killed entry is
  // always a resolved entry as well.
  typedef struct packed {
    logic committed;
    logic killed;
  } entry_status_t;

endpackage : cvxif_sched_pkg

// File: rtl/cvxif_sched_queue.sv
// ---------------------------------------------------------------------------
// cvxif_sched_queue
// In-order circular buffer of accepted offloads with associative commit/kill
// tracking. The head entry is exposed combinationally for dispatch.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i / push_*_i   : enqueue request and entry payload (ignored when full)
//   commit_*_i          : CV-X-IF commit message (id match on all valid entries)
//   pop_i               : remove the head entry (ignored when empty)
//   head_*_o            : view of the oldest entry
//   full_o              : all Depth entries occupied
// ---------------------------------------------------------------------------
module cvxif_sched_queue
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NrRgprPorts = 2,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartidWidth = 1,
  parameter int unsigned Depth       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [OPCODE_W-1:0]           push_opcode_i,
  input  logic [IdWidth-1:0]            push_id_i,
  input  logic [HartidWidth-1:0]        push_hartid_i,
  input  logic [REG_ADDR_W-1:0]         push_rd_i,
  input  logic                          push_we_i,
  input  logic [NrRgprPorts*XLEN-1:0]   push_operands_i,
  input  logic                          commit_valid_i,
  input  logic [IdWidth-1:0]            commit_id_i,
  input  logic                          commit_kill_i,
  input  logic                          pop_i,
  output logic                          head_valid_o,
  output logic [OPCODE_W-1:0]           head_opcode_o,
  output logic [IdWidth-1:0]            head_id_o,
  output logic [HartidWidth-1:0]        head_hartid_o,
  output logic [REG_ADDR_W-1:0]         head_rd_o,
  output logic                          head_we_o,
  output logic [NrRgprPorts*XLEN-1:0]   head_operands_o,
  output logic                          head_committed_o,
  output logic                          head_killed_o,
  output logic                          full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [OPCODE_W-1:0]         opcode;
    logic [IdWidth-1:0]          id;
    logic [HartidWidth-1:0]      hartid;
    logic [REG_ADDR_W-1:0]       rd;
    logic                        we;
    logic [NrRgprPorts*XLEN-1:0] operands;
    entry_status_t               status;
  } entry_t;

  entry_t           r_mem [Depth];
  logic [Depth-1:0] r_valid;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  logic   w_push_match;
  entry_t w_new_entry;
  entry_t w_head;

  assign w_full  = (r_count == CntW'(Depth));
  assign w_empty = (r_count == '0);
  // A full queue never accepts, even when the head leaves in the same cycle.
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !w_empty;

  // A commit arriving together with its own push must not be lost.
  assign w_push_match = commit_valid_i && (commit_id_i == push_id_i);

  assign w_new_entry.opcode           = push_opcode_i;
  assign w_new_entry.id               = push_id_i;
  assign w_new_entry.hartid           = push_hartid_i;
  assign w_new_entry.rd               = push_rd_i;
  assign w_new_entry.we               = push_we_i;
  assign w_new_entry.operands         = push_operands_i;
  assign w_new_entry.status.committed = w_push_match;
  assign w_new_entry.status.killed    = w_push_match && commit_kill_i;

  // Pointers, occupancy and per-slot valid bits.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_wptr          <= r_wptr + 1'b1;
        r_valid[r_wptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr          <= r_rptr + 1'b1;
        r_valid[r_rptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage and associative commit/kill update.
  // NOTE: the payload array has no reset; r_valid alone decides which slots
  // mean anything, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (commit_valid_i && r_valid[i] && (r_mem[i].id == commit_id_i)) begin
        r_mem[i].status.committed <= 1'b1;
        r_mem[i].status.killed    <= commit_kill_i;
      end
    end
    // The write slot is never valid while a push is allowed, so this cannot
    // collide with the commit update above.
    if (w_push) begin
      r_mem[r_wptr] <= w_new_entry;
    end
  end

  assign w_head           = r_mem[r_rptr];
  assign head_valid_o     = !w_empty;
  assign head_opcode_o    = w_head.opcode;
  assign head_id_o        = w_head.id;
  assign head_hartid_o    = w_head.hartid;
  assign head_rd_o        = w_head.rd;
  assign head_we_o        = w_head.we;
  assign head_operands_o  = w_head.operands;
  assign head_committed_o = w_head.status.committed;
  assign head_killed_o    = w_head.status.killed;
  assign full_o           = w_full;

endmodule : cvxif_sched_queue

// File: rtl/cvxif_issue_scheduler.sv
// ---------------------------------------------------------------------------
// cvxif_issue_scheduler
// Buffers accepted CV-X-IF offloads, waits for their commit/kill, dispatches
// committed entries one at a time to a shared multi-cycle execution unit and
// returns each result on a valid/ready result channel.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   issue_*           : decoded instruction in, issue_ready_o = queue not full
//   commit_*_i        : commit/kill message for an outstanding id
//   exe_*             : dispatch handshake + payload, done pulse + result
//   result_*          : registered result channel, held until result_ready_i
// ---------------------------------------------------------------------------
module cvxif_issue_scheduler
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NrRgprPorts = 2,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartidWidth = 1,
  parameter int unsigned Depth       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [OPCODE_W-1:0]           opcode_i,
  input  logic [IdWidth-1:0]            id_i,
  input  logic [HartidWidth-1:0]        hartid_i,
  input  logic [REG_ADDR_W-1:0]         rd_i,
  input  logic                          we_i,
  input  logic [NrRgprPorts*XLEN-1:0]   registers_i,
  input  logic                          commit_valid_i,
  input  logic [IdWidth-1:0]            commit_id_i,
  input  logic                          commit_kill_i,
  output logic                          exe_valid_o,
  input  logic                          exe_ready_i,
  output logic [OPCODE_W-1:0]           exe_opcode_o,
  output logic [NrRgprPorts*XLEN-1:0]   exe_operands_o,
  input  logic                          exe_done_i,
  input  logic [XLEN-1:0]               exe_result_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [IdWidth-1:0]            result_id_o,
  output logic [HartidWidth-1:0]        result_hartid_o,
  output logic [REG_ADDR_W-1:0]         result_rd_o,
  output logic                          result_we_o,
  output logic [XLEN-1:0]               result_data_o
);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic                        w_full;
  logic                        w_head_valid;
  logic [OPCODE_W-1:0]         w_head_opcode;
  logic [IdWidth-1:0]          w_head_id;
  logic [HartidWidth-1:0]      w_head_hartid;
  logic [REG_ADDR_W-1:0]       w_head_rd;
  logic                        w_head_we;
  logic [NrRgprPorts*XLEN-1:0] w_head_operands;
  logic                        w_head_committed;
  logic                        w_head_killed;

  logic w_exe_valid;
  logic w_drop;
  logic w_dispatch;
  logic w_pop;

  logic                   r_result_valid;
  logic [IdWidth-1:0]     r_result_id;
  logic [HartidWidth-1:0] r_result_hartid;
  logic [REG_ADDR_W-1:0]  r_result_rd;
  logic                   r_result_we;
  logic [XLEN-1:0]        r_result_data;

  assign issue_ready_o = !w_full;

  cvxif_sched_queue #(
    .XLEN        (XLEN),
    .NrRgprPorts (NrRgprPorts),
    .IdWidth     (IdWidth),
    .HartidWidth (HartidWidth),
    .Depth       (Depth)
  ) u_queue (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .push_i           (issue_valid_i),
    .push_opcode_i    (opcode_i),
    .push_id_i        (id_i),
    .push_hartid_i    (hartid_i),
    .push_rd_i        (rd_i),
    .push_we_i        (we_i),
    .push_operands_i  (registers_i),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .pop_i            (w_pop),
    .head_valid_o     (w_head_valid),
    .head_opcode_o    (w_head_opcode),
    .head_id_o        (w_head_id),
    .head_hartid_o    (w_head_hartid),
    .head_rd_o        (w_head_rd),
    .head_we_o        (w_head_we),
    .head_operands_o  (w_head_operands),
    .head_committed_o (w_head_committed),
    .head_killed_o    (w_head_killed),
    .full_o           (w_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_exe_valid  = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_head_valid) begin
          if (w_head_killed) begin
            w_drop = 1'b1;
          end else if (w_head_committed) begin
            w_exe_valid = 1'b1;
            if (exe_ready_i) begin
              w_state_next = EXEC;
            end
          end
        end
      end
      // A done pulse is only looked at from the cycle after dispatch onward,
      // which also discards stray pulses from an operation aborted by reset.
      EXEC: begin
        if (exe_done_i) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (result_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_dispatch = w_exe_valid && exe_ready_i;
  assign w_pop      = w_drop || w_dispatch;

  // Payload is forced to zero when not dispatching so the unreset queue
  // storage never shows up on the execution interface.
  assign exe_valid_o    = w_exe_valid;
  assign exe_opcode_o   = w_exe_valid ? w_head_opcode : '0;
  assign exe_operands_o = w_exe_valid ? w_head_operands : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result_valid  <= 1'b0;
      r_result_id     <= '0;
      r_result_hartid <= '0;
      r_result_rd     <= '0;
      r_result_we     <= 1'b0;
      r_result_data   <= '0;
    end else begin
      if (w_dispatch) begin
        r_result_id     <= w_head_id;
        r_result_hartid <= w_head_hartid;
        r_result_rd     <= w_head_rd;
        r_result_we     <= w_head_we;
      end
      if ((r_state == EXEC) && exe_done_i) begin
        r_result_data  <= exe_result_i;
        r_result_valid <= 1'b1;
      end
      if ((r_state == RESP) && result_ready_i) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign result_valid_o  = r_result_valid;
  assign result_id_o     = r_result_id;
  assign result_hartid_o = r_result_hartid;
  assign result_rd_o     = r_result_rd;
  assign result_we_o     = r_result_we;
  assign result_data_o   = r_result_data;

endmodule : cvxif_issue_scheduler
